// File: rtl/adsr_envelope_gen.sv
// ADSR envelope generator for one voice.
// The level is a fixed-point accumulator. Its integer part is the 7-bit
// amplitude sent to the pulse generator. State and level move only on
// sample_tick. A trigger pulse that arrives between ticks is held until the
// next tick.
module adsr_envelope_gen #(
  parameter int ACC_W     = 16,
  parameter int FRAC_BITS = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_tick,
  input  logic             gate,
  input  logic             trigger,
  input  logic [ACC_W-1:0] attack_rate,
  input  logic [ACC_W-1:0] decay_rate,
  input  logic [6:0]       sustain_level,
  input  logic [ACC_W-1:0] release_rate,
  output logic [6:0]       amplitude,
  output logic [2:0]       env_state,
  output logic             active,
  output logic             done
);

  localparam int AMP_W = ACC_W - FRAC_BITS;

  // Full-scale level: every amplitude bit set, fraction cleared.
  localparam logic [ACC_W-1:0] PEAK = {{AMP_W{1'b1}}, {FRAC_BITS{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] env, env_nxt;
  logic             trig_pend;
  logic             done_nxt;

  logic [ACC_W-1:0]        sus;
  logic [ACC_W:0]          attack_sum;
  logic signed [ACC_W:0]   decay_diff;
  logic signed [ACC_W:0]   release_diff;
  logic                    trig_any;
  logic                    in_held_phase;
  logic                    in_rest_phase;

  // The arithmetic is one bit wider than env. The attack carry and any
  // negative subtract result are caught before env is written, so env
  // never wraps.
  assign sus          = {sustain_level, {FRAC_BITS{1'b0}}};
  assign attack_sum   = {1'b0, env} + {1'b0, attack_rate};
  assign decay_diff   = $signed({1'b0, env}) - $signed({1'b0, decay_rate});
  assign release_diff = $signed({1'b0, env}) - $signed({1'b0, release_rate});

  // A trigger on the tick itself counts the same as a pending one.
  assign trig_any      = trig_pend | trigger;
  assign in_held_phase = (state == S_ATTACK) || (state == S_DECAY) ||
                         (state == S_SUSTAIN);
  assign in_rest_phase = (state == S_IDLE) || (state == S_RELEASE);

  // Next state and level for one tick. Gate and trigger events take
  // priority and leave env unchanged on their tick.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    env_nxt   = env;
    done_nxt  = 1'b0;
    if (trig_any && gate) begin
      state_nxt = S_ATTACK;
    end else if (!gate && in_held_phase) begin
      state_nxt = S_RELEASE;
    end else if (gate && in_rest_phase) begin
      state_nxt = S_ATTACK;
    end else begin
      unique case (state)
        S_IDLE: begin
          env_nxt = '0;
        end
        S_ATTACK: begin
          if (attack_sum >= {1'b0, PEAK}) begin
            env_nxt   = PEAK;
            state_nxt = S_DECAY;
          end else begin
            env_nxt = attack_sum[ACC_W-1:0];
          end
        end
        S_DECAY: begin
          if (decay_diff <= $signed({1'b0, sus})) begin
            env_nxt   = sus;
            state_nxt = S_SUSTAIN;
          end else begin
            env_nxt = decay_diff[ACC_W-1:0];
          end
        end
        S_SUSTAIN: begin
          env_nxt = sus;
        end
        S_RELEASE: begin
          if (release_diff <= $signed({(ACC_W+1){1'b0}})) begin
            env_nxt   = '0;
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end else begin
            env_nxt = release_diff[ACC_W-1:0];
          end
        end
        default: begin
          env_nxt   = '0;
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State, level and done change only on a tick. done is cleared on
  // every other clock, so it stays high for exactly one clock.
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples values from before the edge, whatever order the registers are
  // written in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      env   <= '0;
      done  <= 1'b0;
    end else if (sample_tick) begin
      state <= state_nxt;
      env   <= env_nxt;
      done  <= done_nxt;
    end else begin
      done  <= 1'b0;
    end
  end

  // Hold a trigger that arrives between ticks. The next tick uses it or
  // drops it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_pend <= 1'b0;
    end else if (sample_tick) begin
      trig_pend <= 1'b0;
    end else if (trigger) begin
      trig_pend <= 1'b1;
    end
  end

  assign amplitude = env[ACC_W-1:FRAC_BITS];
  assign env_state = state;
  assign active    = (state != S_IDLE);

endmodule

// File: doc/adsr_envelope_gen.md
Name: adsr_envelope_gen

Overview:
Per-voice ADSR envelope generator that produces the 7-bit amplitude feeding the pulse wave generator's amplitude input. It advances once per 20 kHz sample_tick and is driven by a note gate and a retrigger pulse from the note/key logic. Rates are per-sample increments on a 16-bit fixed-point level whose top 7 bits form the amplitude.

Parameters:
ACC_W, 16, envelope accumulator width in bits.
FRAC_BITS, 9, fractional bits; amplitude = env[ACC_W-1:FRAC_BITS]; ACC_W-FRAC_BITS must equal 7.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
sample_tick  in  1  one-clk pulse at the sample rate (20 kHz)
gate  in  1  note held (level)
trigger  in  1  one-clk pulse forcing a restart of ATTACK
attack_rate  in  16  per-tick increment in ATTACK (LSB = 1/512 amplitude step)
decay_rate  in  16  per-tick decrement in DECAY
sustain_level  in  7  sustain amplitude, 0..127
release_rate  in  16  per-tick decrement in RELEASE
amplitude  out  7  env[15:9], to pulse generator
env_state  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
active  out  1  high when env_state != IDLE
done  out  1  one-clk pulse on RELEASE->IDLE

Behaviour:
- Reset (async, rst=1): env=0, state=IDLE, trig_pend=0, done=0; hence amplitude=0, env_state=0, active=0.
- PEAK = 127<<9 = 16'hFE00; SUS = sustain_level<<9. Arithmetic in 17-bit unsigned, or 17-bit signed for subtracts; no wrap-around ever reaches env.
- trigger sets trig_pend on any clk; trig_pend is cleared on the next sample_tick, where it is consumed. trigger coinciding with sample_tick is consumed on that tick.
- State and env change only on clk edges where sample_tick=1; otherwise they hold. amplitude is combinational from env, so it updates 1 clk after the tick edge.
- Per-tick evaluation, priority order:
  1. trig_pend|trigger asserted and gate=1 -> ATTACK, env unchanged this tick (retrigger from current level, no zeroing).
  2. gate=0 and state in ATTACK/DECAY/SUSTAIN -> RELEASE, env unchanged this tick.
  3. gate=1 and state in IDLE/RELEASE -> ATTACK, env unchanged this tick.
  4. Otherwise apply the current state's update:
     IDLE: env=0.
     ATTACK: s=env+attack_rate; if s>=PEAK then env=PEAK, ->DECAY; else env=s.
     DECAY: d=env-decay_rate; if d<=SUS then env=SUS, ->SUSTAIN; else env=d.
     SUSTAIN: env=SUS, tracking sustain_level changes on each tick.
     RELEASE: r=env-release_rate; if r<=0 then env=0, ->IDLE, done=1 for that clk; else env=r.
- A rate of 0 stalls that phase indefinitely and is legal. sustain_level=127 makes DECAY go to SUSTAIN on its first tick.
- A trigger with gate=0 is dropped: no state change, and trig_pend clears.
- done is registered and high exactly one clk. done=0 in every other case.
- Reset asserted mid-envelope: immediate return to reset values, with no done pulse.

Test Plan:
- Reset, then gate=1, attack_rate=512, decay_rate=512, sustain_level=64, ticks every 10 clk -> ATTACK at tick 1; amplitude rises 1 per tick; 127 at tick 128; state DECAY, then amplitude falls 1/tick to 64, SUSTAIN at tick 192 (±1 counted from the entry tick).
- In SUSTAIN at 64, set sustain_level=100 -> amplitude=100 one clk after the next tick; state stays SUSTAIN.
- gate 1->0 in SUSTAIN at 100, release_rate=1024 -> RELEASE next tick; amplitude falls 2/tick; reaches 0 and IDLE after 50 update ticks; done high exactly 1 clk; active=0.
- In RELEASE at amplitude 40, gate=1 -> ATTACK next tick; amplitude continues up from 40 (not 0).
- In SUSTAIN with gate held, pulse trigger between ticks -> ATTACK on next tick from sustain level. A trigger with gate=0 in IDLE -> no change.
- attack_rate=16'hFFFF from IDLE -> amplitude 127, DECAY after one update tick with no overflow. Assert rst mid-ATTACK -> amplitude=0, IDLE immediately, no done pulse.
